// File: rtl/victim_cache_control_if.sv
// L1-side request/response handshake of the victim cache controller.
// The master is the L1 cache controller. The slave is victim_cache_control.
interface victim_cache_control_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;

  modport master (
    output mem_read,
    output mem_write,
    input  mem_resp
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    output mem_resp
  );
endinterface

// File: rtl/victim_cache_control.sv
// Control FSM for the 4-entry fully-associative victim cache, with a pmem response watchdog.
// Optional performance counters are enabled by defining VICTIM_PERF_CNT_EN.
module victim_cache_control #(
  parameter int TIMEOUT_W = 8,
  parameter int MAX_WAIT  = 200
) (
  input  logic                   clk,
  input  logic                   reset_n,
  victim_cache_control_if.slave  l1,
  input  logic                   tag_match,
  input  logic                   valid,
  input  logic                   dirty_out,
  input  logic                   pmem_resp,
  output logic                   ld_cache,
  output logic                   ld_data_reg,
  output logic                   miss_get,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic                   busy,
  output logic                   pmem_timeout
`ifdef VICTIM_PERF_CNT_EN
  ,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count,
  output logic [15:0]            wb_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT,
    S_FETCH,
    S_CAPTURE,
    S_WRITEBACK,
    S_STORE,
    S_DONE
  } state_e;

  typedef struct packed {
    logic resp;
    logic ld_cache;
    logic ld_data_reg;
    logic miss_get;
    logic pmem_read;
    logic pmem_write;
    logic busy;
  } outs_t;

  state_e               state;
  state_e               state_next;
  outs_t                outs;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 in_wait;
  logic                 expire;

  function automatic outs_t decode(input state_e s);
    outs_t o;
    o = '0;
    case (s)
      S_HIT:       begin o.resp = 1'b1; o.ld_cache = 1'b1; end
      S_FETCH:     begin o.pmem_read = 1'b1; o.miss_get = 1'b1; end
      S_CAPTURE:   o.ld_data_reg = 1'b1;
      S_WRITEBACK: o.pmem_write = 1'b1;
      S_STORE:     begin o.resp = 1'b1; o.ld_cache = 1'b1; end
      default:     ;
    endcase
    o.busy = (s != S_IDLE);
    return o;
  endfunction

  assign in_wait = (state == S_FETCH) || (state == S_WRITEBACK);
  // The watchdog fires in the MAX_WAIT-th unanswered wait cycle; a pmem_resp in that cycle wins.
  assign expire  = in_wait && !pmem_resp && (wait_cnt == TIMEOUT_W'(MAX_WAIT - 1));

  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      S_IDLE: begin
        if (l1.mem_write) begin
          if (tag_match && valid)      state_next = S_STORE;
          else if (valid && dirty_out) state_next = S_CAPTURE;
          else                         state_next = S_STORE;
        end else if (l1.mem_read) begin
          if (tag_match && valid)      state_next = S_HIT;
          else                         state_next = S_FETCH;
        end
      end
      S_HIT:       state_next = S_DONE;
      S_FETCH:     if (pmem_resp || expire) state_next = S_DONE;
      S_CAPTURE:   state_next = S_WRITEBACK;
      S_WRITEBACK: begin
        if (pmem_resp)   state_next = S_STORE;
        else if (expire) state_next = S_DONE;
      end
      S_STORE:     state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they are glitch-free Moore signals.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      outs         <= '0;
      wait_cnt     <= '0;
      pmem_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state <= state_next;
      outs  <= decode(state_next);
      if (!in_wait)
        wait_cnt <= '0;
      else if (!pmem_resp && (wait_cnt != '1))
        wait_cnt <= wait_cnt + 1'b1;
      if (expire)
        pmem_timeout <= 1'b1;
    end
  end

  assign l1.mem_resp  = outs.resp || ((state == S_FETCH) && pmem_resp) || expire;
  assign ld_cache     = outs.ld_cache;
  assign ld_data_reg  = outs.ld_data_reg;
  assign miss_get     = outs.miss_get;
  assign pmem_read    = outs.pmem_read;
  assign pmem_write   = outs.pmem_write;
  assign busy         = outs.busy;

`ifdef VICTIM_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if ((state == S_IDLE) && (state_next == S_HIT) && (hit_count != '1))
        hit_count <= hit_count + 1'b1;
      if ((state == S_IDLE) && (state_next == S_FETCH) && (miss_count != '1))
        miss_count <= miss_count + 1'b1;
      if ((state == S_CAPTURE) && (wb_count != '1))
        wb_count <= wb_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_victim_cache_control.sv
// Directed self-checking bench for victim_cache_control.
// Output vector order: {mem_resp, ld_cache, ld_data_reg, miss_get, pmem_read, pmem_write, busy, pmem_timeout}.
module tb_victim_cache_control;

  logic clk = 1'b0;
  logic reset_n;
  logic tag_match, valid, dirty_out, pmem_resp, wd_pmem_resp;
  logic ld_cache, ld_data_reg, miss_get, pmem_read, pmem_write, busy, pmem_timeout;
  logic wd_ld_cache, wd_ld_data_reg, wd_miss_get, wd_pmem_read, wd_pmem_write, wd_busy, wd_pmem_timeout;
`ifdef VICTIM_PERF_CNT_EN
  logic [15:0] hit_count, miss_count, wb_count;
  logic [15:0] wd_hit_count, wd_miss_count, wd_wb_count;
`endif
  int checks = 0;
  int errors = 0;

  victim_cache_control_if l1_if ();
  victim_cache_control_if wd_if ();

  always #5 clk = ~clk;

  victim_cache_control dut (
    .clk(clk), .reset_n(reset_n), .l1(l1_if.slave),
    .tag_match(tag_match), .valid(valid), .dirty_out(dirty_out), .pmem_resp(pmem_resp),
    .ld_cache(ld_cache), .ld_data_reg(ld_data_reg), .miss_get(miss_get),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .busy(busy), .pmem_timeout(pmem_timeout)
`ifdef VICTIM_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  victim_cache_control #(.TIMEOUT_W(8), .MAX_WAIT(4)) dut_wd (
    .clk(clk), .reset_n(reset_n), .l1(wd_if.slave),
    .tag_match(tag_match), .valid(valid), .dirty_out(dirty_out), .pmem_resp(wd_pmem_resp),
    .ld_cache(wd_ld_cache), .ld_data_reg(wd_ld_data_reg), .miss_get(wd_miss_get),
    .pmem_read(wd_pmem_read), .pmem_write(wd_pmem_write), .busy(wd_busy), .pmem_timeout(wd_pmem_timeout)
`ifdef VICTIM_PERF_CNT_EN
    , .hit_count(wd_hit_count), .miss_count(wd_miss_count), .wb_count(wd_wb_count)
`endif
  );

  logic [7:0] obs, wd_obs;
  assign obs    = {l1_if.mem_resp, ld_cache, ld_data_reg, miss_get, pmem_read, pmem_write, busy, pmem_timeout};
  assign wd_obs = {wd_if.mem_resp, wd_ld_cache, wd_ld_data_reg, wd_miss_get, wd_pmem_read, wd_pmem_write,
                   wd_busy, wd_pmem_timeout};

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp [0:3];
    reset_n = 1'b0;
    l1_if.mem_read = 1'b0; l1_if.mem_write = 1'b0; wd_if.mem_read = 1'b0; wd_if.mem_write = 1'b0;
    tag_match = 1'b0; valid = 1'b0; dirty_out = 1'b0; pmem_resp = 1'b0; wd_pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 8'h00 || wd_obs !== 8'h00) begin
      errors++; $display("FAIL reset_state got %b/%b want 00000000", obs, wd_obs);
    end
    adv(); reset_n = 1'b1;
    // Start a lookup miss and abort it with reset after two FETCH cycles.
    exp = '{8'b0000_0000, 8'b0001_1010, 8'b0001_1010, 8'b0000_0000};
    for (int i = 0; i < 3; i++) begin
      adv(); l1_if.mem_read = 1'b1; valid = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL reset_fetch[%0d] got %b want %b", i, obs, exp[i]); end
    end
    #2 reset_n = 1'b0; l1_if.mem_read = 1'b0;
    #1;
    checks++;
    if (obs !== 8'h00) begin errors++; $display("FAIL reset_async_drop got %b want 00000000", obs); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      adv(); pmem_resp = (i == 1);
      @(negedge clk);
      checks++;
      if (obs !== exp[3]) begin errors++; $display("FAIL reset_after_release[%0d] got %b want %b", i, obs, exp[3]); end
    end
    pmem_resp = 1'b0;
  endtask

  task automatic test_read_hit();
    logic [7:0] exp [0:3];
    exp = '{8'b0000_0000, 8'b1100_0010, 8'b0000_0010, 8'b0000_0000};
    for (int i = 0; i < 4; i++) begin
      adv(); l1_if.mem_read = (i < 2); tag_match = 1'b1; valid = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL read_hit[%0d] got %b want %b", i, obs, exp[i]); end
    end
  endtask

  task automatic test_read_miss();
    logic [7:0] exp [0:7];
    exp = '{8'b0000_0000, 8'b0001_1010, 8'b0001_1010, 8'b0001_1010,
            8'b0001_1010, 8'b1001_1010, 8'b0000_0010, 8'b0000_0000};
    for (int i = 0; i < 8; i++) begin
      adv(); l1_if.mem_read = (i < 6); tag_match = 1'b0; valid = 1'b1; pmem_resp = (i == 5);
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL read_miss[%0d] got %b want %b", i, obs, exp[i]); end
    end
    pmem_resp = 1'b0;
  endtask

  task automatic test_dirty_insert();
    logic [7:0] exp [0:7];
    exp = '{8'b0000_0000, 8'b0010_0010, 8'b0000_0110, 8'b0000_0110,
            8'b0000_0110, 8'b1100_0010, 8'b0000_0010, 8'b0000_0000};
    for (int i = 0; i < 8; i++) begin
      adv(); l1_if.mem_write = (i < 6); tag_match = 1'b0; valid = 1'b1; dirty_out = 1'b1; pmem_resp = (i == 4);
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL dirty_insert[%0d] got %b want %b", i, obs, exp[i]); end
    end
    pmem_resp = 1'b0; dirty_out = 1'b0;
  endtask

  // Clean LRU with both requests high, then a dirty in-place match; both must take the STORE path.
  // A stray pmem_resp in STORE and in IDLE must change nothing.
  task automatic test_clean_insert();
    logic [7:0] exp [0:3];
    exp = '{8'b0000_0000, 8'b1100_0010, 8'b0000_0010, 8'b0000_0000};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        adv();
        l1_if.mem_write = (i < 2); l1_if.mem_read = (i < 2) && (k == 0);
        tag_match = (k == 1); valid = 1'b1; dirty_out = (k == 1); pmem_resp = (i == 1) || (i == 3);
        @(negedge clk);
        checks++;
        if (obs !== exp[i]) begin errors++; $display("FAIL clean_insert%0d[%0d] got %b want %b", k, i, obs, exp[i]); end
      end
    end
    pmem_resp = 1'b0; dirty_out = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [0:6];
    exp = '{8'b0000_0000, 8'b1100_0010, 8'b0000_0010, 8'b0000_0000,
            8'b1100_0010, 8'b0000_0010, 8'b0000_0000};
    for (int i = 0; i < 7; i++) begin
      adv(); l1_if.mem_read = (i < 2) || (i == 3) || (i == 4); tag_match = 1'b1; valid = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL back_to_back[%0d] got %b want %b", i, obs, exp[i]); end
    end
  endtask

`ifdef VICTIM_PERF_CNT_EN
  task automatic test_perf();
    @(negedge clk);
    checks++;
    if (hit_count !== 16'd3 || miss_count !== 16'd1 || wb_count !== 16'd1) begin
      errors++;
      $display("FAIL perf_counts got %0d/%0d/%0d want 3/1/1", hit_count, miss_count, wb_count);
    end
  endtask
`endif

  task automatic test_timeout_race();
    logic [7:0] exp [0:6];
    exp = '{8'b0000_0000, 8'b0001_1010, 8'b0001_1010, 8'b0001_1010,
            8'b1001_1010, 8'b0000_0010, 8'b0000_0000};
    for (int i = 0; i < 7; i++) begin
      adv(); wd_if.mem_read = (i < 5); tag_match = 1'b0; valid = 1'b1; wd_pmem_resp = (i == 4);
      @(negedge clk);
      checks++;
      if (wd_obs !== exp[i]) begin errors++; $display("FAIL timeout_race[%0d] got %b want %b", i, wd_obs, exp[i]); end
    end
    wd_pmem_resp = 1'b0;
  endtask

  task automatic test_timeout();
    logic [7:0] exp [0:8];
    exp = '{8'b0000_0000, 8'b0001_1010, 8'b0001_1010, 8'b0001_1010, 8'b1001_1010,
            8'b0000_0011, 8'b0000_0001, 8'b0000_0001, 8'b0000_0001};
    for (int i = 0; i < 9; i++) begin
      adv(); wd_if.mem_read = (i < 5); tag_match = 1'b0; valid = 1'b1;
      @(negedge clk);
      checks++;
      if (wd_obs !== exp[i]) begin errors++; $display("FAIL timeout[%0d] got %b want %b", i, wd_obs, exp[i]); end
    end
    adv(); reset_n = 1'b0;
    #1;
    checks++;
    if (wd_obs !== 8'h00) begin errors++; $display("FAIL timeout_cleared got %b want 00000000", wd_obs); end
    adv(); reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_read_miss();
    test_dirty_insert();
    test_clean_insert();
    test_back_to_back();
`ifdef VICTIM_PERF_CNT_EN
    test_perf();
`endif
    test_timeout_race();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

endmodule
